// File: rtl/pwm_driver.sv
// Two-channel PWM driver with a shared prescaled 64-step timebase.
// Target duties are taken only at period boundaries and are either applied
// directly or slewed by one LSB per period, depending on SLEW_EN.
module pwm_driver #(
  parameter int PRESCALE = 16,
  parameter bit SLEW_EN  = 1'b1
) (
  input  logic       sysclk,
  input  logic       Reset,
  input  logic       En,
  input  logic [5:0] DC_X,
  input  logic [5:0] DC_Y,
  output logic       PWM_X,
  output logic       PWM_Y,
  output logic [5:0] Cur_X,
  output logic [5:0] Cur_Y,
  output logic       Period_Start
);

  // Prescaler must hold 0..PRESCALE-1; PRESCALE is at least 2, so one bit minimum.
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_r;
  logic [5:0]    period_r;
  logic          tick_s;
  logic          boundary_s;
  logic [5:0]    next_x_s;
  logic [5:0]    next_y_s;

  // One-LSB move toward the target; saturates naturally since the target is in range.
  function automatic logic [5:0] slew_step(input logic [5:0] cur, input logic [5:0] tgt);
    logic [5:0] res;
    if (tgt > cur) begin
      res = cur + 6'd1;
    end else if (tgt < cur) begin
      res = cur - 6'd1;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Tick/boundary decode and the duty that would be applied at the next boundary.
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    next_x_s   = Cur_X;
    next_y_s   = Cur_Y;
    if (En && (presc_r == PRESC_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (tick_s && (period_r == 6'd63)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
    if (SLEW_EN) begin
      next_x_s = slew_step(Cur_X, DC_X);
      next_y_s = slew_step(Cur_Y, DC_Y);
    end else begin
      next_x_s = DC_X;
      next_y_s = DC_Y;
    end
  end

  // Prescaler and period counter; En low parks both at zero so a restart begins a fresh period.
  always_ff @(posedge sysclk or posedge Reset) begin
    if (Reset) begin
      presc_r  <= PRESC_ZERO;
      period_r <= 6'd0;
    end else if (!En) begin
      presc_r  <= PRESC_ZERO;
      period_r <= 6'd0;
    end else if (tick_s) begin
      presc_r  <= PRESC_ZERO;
      period_r <= period_r + 6'd1;
    end else begin
      presc_r  <= presc_r + PRESC_ONE;
    end
  end

  // Applied duties change only on a boundary seen while enabled; En low holds them.
  always_ff @(posedge sysclk or posedge Reset) begin
    if (Reset) begin
      Cur_X <= 6'd0;
      Cur_Y <= 6'd0;
    end else if (En && boundary_s) begin
      Cur_X <= next_x_s;
      Cur_Y <= next_y_s;
    end else begin
      Cur_X <= Cur_X;
      Cur_Y <= Cur_Y;
    end
  end

  // Registered waveforms and boundary pulse, all forced low while disabled.
  always_ff @(posedge sysclk or posedge Reset) begin
    if (Reset) begin
      PWM_X        <= 1'b0;
      PWM_Y        <= 1'b0;
      Period_Start <= 1'b0;
    end else if (!En) begin
      PWM_X        <= 1'b0;
      PWM_Y        <= 1'b0;
      Period_Start <= 1'b0;
    end else begin
      PWM_X        <= (period_r < Cur_X);
      PWM_Y        <= (period_r < Cur_Y);
      Period_Start <= boundary_s;
    end
  end

endmodule

// File: doc/pwm_driver.md
PWM_DRIVER -- requirements
Module: pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE, default 16: sysclk cycles per PWM tick, legal range 2..4096.
REQ-002 SHALL have parameter SLEW_EN, default 1: 1 = applied duty steps by at most 1 LSB per period, 0 = applied duty loads directly.
REQ-003 SHALL have port sysclk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port En  in  1  run enable, synchronous.
REQ-006 SHALL have port DC_X  in  6  target duty for channel X, from the playback RAM, 0..63.
REQ-007 SHALL have port DC_Y  in  6  target duty for channel Y, 0..63.
REQ-008 SHALL have port PWM_X  out  1  channel X PWM waveform, registered.
REQ-009 SHALL have port PWM_Y  out  1  channel Y PWM waveform, registered.
REQ-010 SHALL have port Cur_X  out  6  duty currently applied to channel X.
REQ-011 SHALL have port Cur_Y  out  6  duty currently applied to channel Y.
REQ-012 SHALL have port Period_Start  out  1  one-cycle pulse at each period boundary.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 while En=1 and wrap to 0; tick = prescaler at PRESCALE-1.
REQ-014 The 6-bit period counter SHALL increment on each tick and wrap 63->0, so one period = 64*PRESCALE sysclk cycles.
REQ-015 Boundary = the tick on which the period counter wraps 63->0; Period_Start SHALL be 1 in the cycle after the boundary edge, otherwise 0.
REQ-016 Targets DC_X/DC_Y SHALL be sampled only at a boundary; changes mid-period SHALL have no effect until the next boundary.
REQ-017 With SLEW_EN=0, Cur_X SHALL load DC_X at the boundary.
REQ-018 With SLEW_EN=1, Cur_X SHALL become Cur_X+1 if DC_X>Cur_X, Cur_X-1 if DC_X<Cur_X, unchanged if equal; no wrap, so values stay within 0..63.
REQ-019 Channel Y SHALL follow REQ-016..018 independently with DC_Y/Cur_Y.
REQ-020 PWM_X SHALL be registered from (En and period counter < Cur_X), giving 1 sysclk latency vs. counter state; same for PWM_Y with Cur_Y.
REQ-021 Duty 0 SHALL give a constantly low output; duty 63 SHALL give high for 63 of 64 ticks; duty N SHALL give high for N*PRESCALE cycles per period.
REQ-022 En=0 SHALL clear prescaler and period counter to 0 synchronously and force PWM_X, PWM_Y, Period_Start to 0 from the next edge.
REQ-023 En=0 SHALL leave Cur_X and Cur_Y held.
REQ-024 On En 0->1, counting SHALL restart from prescaler=0 and period=0, and the first boundary SHALL occur 64*PRESCALE cycles later.
REQ-025 When a boundary coincides with En falling, En=0 SHALL take priority: no Cur update and no Period_Start.

Reset
REQ-026 Reset=1 SHALL immediately, without waiting for a clock edge, force prescaler=0, period counter=0, Cur_X=Cur_Y=0, PWM_X=PWM_Y=0 and Period_Start=0.
REQ-027 Reset asserted mid-period SHALL abandon the period; after release with En=1, timing SHALL restart per REQ-024.

Verification (PRESCALE=4, period=256 cycles)
REQ-028 SLEW_EN=0, En=1, DC_X=16 -> after the first boundary Cur_X=16, and PWM_X is high exactly 64 consecutive cycles per 256-cycle period; Period_Start is 1 once per 256 cycles.
REQ-029 SLEW_EN=1, DC_Y changes 0->5 -> Cur_Y reads 1,2,3,4,5 over the next five boundaries, then stays at 5; DC_Y changes 5->3 -> Cur_Y reads 4,3.
REQ-030 DC_X=0 and DC_Y=63, SLEW_EN=0 -> PWM_X is never high; PWM_Y is high 252 of every 256 cycles, low for the last 4.
REQ-031 DC_X changes from 10 to 40 mid-period -> the current period still shows 40 high cycles (duty 10); the next period shows 160 high cycles.
REQ-032 Reset asserted between clock edges mid-period -> all outputs are 0 before the next edge; after release, the first Period_Start occurs 256 cycles after En is seen high.
REQ-033 En dropped for 100 cycles mid-period -> PWM outputs are low and Cur values are unchanged during the gap; after En returns, the period restarts at 0.
